// File: rtl/stage_vote_filter.sv
// Confidence-gated majority-vote smoother for per-epoch ANN sleep-stage results.
// Accepted stages fill a sliding window; the most popular stage in it is emitted over valid/ready.
module stage_vote_filter #(
    parameter int                 WIN        = 5,
    parameter logic signed [15:0] MARGIN_MIN = 16'sd64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] o0,
    input  logic signed [15:0] o1,
    input  logic signed [15:0] o2,
    input  logic signed [15:0] o3,
    input  logic        [1:0]  predicted_stage,
    output logic               out_valid,
    input  logic               out_ready,
    output logic        [1:0]  out_stage,
    output logic        [3:0]  out_count,
    output logic               out_lowconf,
    output logic        [15:0] epoch_cnt
);

    localparam int                 PTR_W   = (WIN > 1) ? $clog2(WIN) : 1;
    localparam logic [3:0]         WIN_L   = 4'(WIN);
    localparam logic [PTR_W-1:0]   PTR_MAX = PTR_W'(WIN - 1);
    localparam logic signed [16:0] MIN_EXT = {MARGIN_MIN[15], MARGIN_MIN};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MARGIN = 3'd1,
        UPDATE = 3'd2,
        VOTE   = 3'd3,
        OUT    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic signed [15:0] score_q [4];
    logic signed [15:0] score_d [4];
    logic [1:0]         pred_q, pred_d;
    logic               lowconf_q, lowconf_d;
    logic [1:0]         buf_q [WIN];
    logic [1:0]         buf_d [WIN];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [3:0]         fill_q, fill_d;
    logic [3:0]         hist_q [4];
    logic [3:0]         hist_d [4];
    logic [1:0]         out_stage_q, out_stage_d;
    logic [3:0]         out_count_q, out_count_d;
    logic               out_lowconf_q, out_lowconf_d;
    logic [15:0]        epoch_cnt_q, epoch_cnt_d;

    logic signed [15:0] second_s;
    logic signed [16:0] margin_s;
    logic [3:0]         max_cnt_s;
    logic [1:0]         winner_s;
    logic               found_s;

    assign in_ready    = (state_q == IDLE) && !rst;
    assign out_valid   = (state_q == OUT);
    assign out_stage   = out_stage_q;
    assign out_count   = out_count_q;
    assign out_lowconf = out_lowconf_q;
    assign epoch_cnt   = epoch_cnt_q;

    // Margin between the predicted class score and the best competing score, kept 17-bit signed.
    always_comb begin
        second_s = 16'sh8000;
        for (int i = 0; i < 4; i++) begin
            if ((2'(i) != pred_q) && (score_q[i] > second_s)) begin
                second_s = score_q[i];
            end else begin
                second_s = second_s;
            end
        end
        margin_s = {score_q[pred_q][15], score_q[pred_q]} - {second_s[15], second_s};
    end

    // Winner selection: highest count, ties keep the current stage else the lowest index.
    always_comb begin
        max_cnt_s = 4'd0;
        winner_s  = 2'd0;
        found_s   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (hist_q[i] > max_cnt_s) begin
                max_cnt_s = hist_q[i];
            end else begin
                max_cnt_s = max_cnt_s;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (!found_s && (hist_q[i] == max_cnt_s)) begin
                winner_s = 2'(i);
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
        if (fill_q == 4'd0) begin
            winner_s = pred_q;
        end else if (hist_q[out_stage_q] == max_cnt_s) begin
            winner_s = out_stage_q;
        end else begin
            winner_s = winner_s;
        end
    end

    // Next-state and datapath updates for the five-state epoch sequencer.
    always_comb begin
        state_d       = state_q;
        score_d       = score_q;
        pred_d        = pred_q;
        lowconf_d     = lowconf_q;
        buf_d         = buf_q;
        wr_ptr_d      = wr_ptr_q;
        fill_d        = fill_q;
        hist_d        = hist_q;
        out_stage_d   = out_stage_q;
        out_count_d   = out_count_q;
        out_lowconf_d = out_lowconf_q;
        epoch_cnt_d   = epoch_cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    score_d[0] = o0;
                    score_d[1] = o1;
                    score_d[2] = o2;
                    score_d[3] = o3;
                    pred_d     = predicted_stage;
                    state_d    = MARGIN;
                end else begin
                    state_d    = IDLE;
                end
            end
            MARGIN: begin
                lowconf_d = (margin_s < MIN_EXT);
                state_d   = UPDATE;
            end
            UPDATE: begin
                if (!lowconf_q) begin
                    // Decrement-then-increment leaves hist unchanged when pred equals the evicted stage.
                    if (fill_q == WIN_L) begin
                        hist_d[buf_q[wr_ptr_q]] = hist_d[buf_q[wr_ptr_q]] - 4'd1;
                    end else begin
                        fill_d = fill_q + 4'd1;
                    end
                    hist_d[pred_q]  = hist_d[pred_q] + 4'd1;
                    buf_d[wr_ptr_q] = pred_q;
                    wr_ptr_d = (wr_ptr_q == PTR_MAX) ? {PTR_W{1'b0}} : wr_ptr_q + PTR_W'(1);
                end else begin
                    fill_d = fill_q;
                end
                state_d = VOTE;
            end
            VOTE: begin
                out_stage_d   = winner_s;
                out_count_d   = (fill_q == 4'd0) ? 4'd0 : hist_q[winner_s];
                out_lowconf_d = lowconf_q;
                state_d       = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    if (epoch_cnt_q != 16'hFFFF) begin
                        epoch_cnt_d = epoch_cnt_q + 16'd1;
                    end else begin
                        epoch_cnt_d = epoch_cnt_q;
                    end
                    state_d = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            score_q       <= '{default: 16'sd0};
            pred_q        <= 2'd0;
            lowconf_q     <= 1'b0;
            buf_q         <= '{default: 2'd0};
            wr_ptr_q      <= {PTR_W{1'b0}};
            fill_q        <= 4'd0;
            hist_q        <= '{default: 4'd0};
            out_stage_q   <= 2'd0;
            out_count_q   <= 4'd0;
            out_lowconf_q <= 1'b0;
            epoch_cnt_q   <= 16'd0;
        end else begin
            state_q       <= state_d;
            score_q       <= score_d;
            pred_q        <= pred_d;
            lowconf_q     <= lowconf_d;
            buf_q         <= buf_d;
            wr_ptr_q      <= wr_ptr_d;
            fill_q        <= fill_d;
            hist_q        <= hist_d;
            out_stage_q   <= out_stage_d;
            out_count_q   <= out_count_d;
            out_lowconf_q <= out_lowconf_d;
            epoch_cnt_q   <= epoch_cnt_d;
        end
    end

endmodule

// File: tb/tb_stage_vote_filter.sv
// Directed bench for stage_vote_filter: hand-computed expected stages, counts and latencies.
module tb_stage_vote_filter;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] o0 = 16'sd0, o1 = 16'sd0, o2 = 16'sd0, o3 = 16'sd0;
    logic [1:0]         predicted_stage = 2'd0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [1:0]         out_stage;
    logic [3:0]         out_count;
    logic               out_lowconf;
    logic [15:0]        epoch_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_ep  = 0;

    stage_vote_filter #(.WIN(5), .MARGIN_MIN(16'sd64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .o0(o0), .o1(o1), .o2(o2), .o3(o3), .predicted_stage(predicted_stage),
        .out_valid(out_valid), .out_ready(out_ready), .out_stage(out_stage),
        .out_count(out_count), .out_lowconf(out_lowconf), .epoch_cnt(epoch_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {15'd0, in_ready}, 16'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_ep = 0;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_out_stage", {14'd0, out_stage}, 16'd0);
        chk("rst_out_count", {12'd0, out_count}, 16'd0);
        chk("rst_out_lowconf", {15'd0, out_lowconf}, 16'd0);
        chk("rst_epoch_cnt", epoch_cnt, 16'd0);
        chk("rst_idle_ready", {15'd0, in_ready}, 16'd1);
    endtask

    // Called at a negedge in IDLE; returns just after the accepting edge.
    task automatic accept(input logic signed [15:0] a, input logic signed [15:0] b,
                          input logic signed [15:0] c, input logic signed [15:0] d,
                          input logic [1:0] p);
        chk("accept_in_ready", {15'd0, in_ready}, 16'd1);
        o0 = a; o1 = b; o2 = c; o3 = d; predicted_stage = p;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("latency_low", {15'd0, out_valid}, 16'd0);
        end
        @(negedge clk);
        chk("latency_high", {15'd0, out_valid}, 16'd1);
    endtask

    task automatic check_out(input logic [1:0] st, input logic [3:0] cnt, input logic lc);
        chk("out_stage", {14'd0, out_stage}, {14'd0, st});
        chk("out_count", {12'd0, out_count}, {12'd0, cnt});
        chk("out_lowconf", {15'd0, out_lowconf}, {15'd0, lc});
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        exp_ep++;
        @(negedge clk);
        chk("hs_out_valid", {15'd0, out_valid}, 16'd0);
        chk("hs_epoch_cnt", epoch_cnt, 16'(exp_ep));
        chk("hs_in_ready", {15'd0, in_ready}, 16'd1);
    endtask

    task automatic epoch(input logic signed [15:0] a, input logic signed [15:0] b,
                         input logic signed [15:0] c, input logic signed [15:0] d,
                         input logic [1:0] p, input logic [1:0] st,
                         input logic [3:0] cnt, input logic lc);
        accept(a, b, c, d, p);
        wait_out();
        check_out(st, cnt, lc);
        handshake();
    endtask

    task automatic hi_epoch(input logic [1:0] p, input logic [1:0] st, input logic [3:0] cnt);
        epoch((p == 2'd0) ? 16'sd512 : 16'sd0, (p == 2'd1) ? 16'sd512 : 16'sd0,
              (p == 2'd2) ? 16'sd512 : 16'sd0, (p == 2'd3) ? 16'sd512 : 16'sd0,
              p, st, cnt, 1'b0);
    endtask

    initial begin
        logic [1:0] seq_in  [7] = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2};
        logic [1:0] seq_st  [7] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
        logic [3:0] seq_cnt [7] = '{4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};

        // Reset state and scenario 1
        do_reset();
        check_reset_outputs();
        epoch(16'sd512, 16'sd100, 16'sd50, 16'sd0, 2'd0, 2'd0, 4'd1, 1'b0);

        // Scenario 2: low margin with empty window, then a confident epoch
        do_reset();
        epoch(16'sd300, 16'sd280, 16'sd0, 16'sd0, 2'd0, 2'd0, 4'd0, 1'b1);
        hi_epoch(2'd2, 2'd2, 4'd1);

        // Scenario 3: smoothing, eviction and pointer wrap
        do_reset();
        for (int i = 0; i < 7; i++) begin
            hi_epoch(seq_in[i], seq_st[i], seq_cnt[i]);
        end

        // Scenario 4: tie hold, then margin boundaries and negative margin
        do_reset();
        hi_epoch(2'd3, 2'd3, 4'd1);
        hi_epoch(2'd0, 2'd3, 4'd1);
        hi_epoch(2'd0, 2'd0, 4'd2);
        epoch(16'sd512, 16'sd100, 16'sd0, 16'sd0, 2'd1, 2'd0, 4'd2, 1'b1);
        epoch(16'sd64, 16'sd0, 16'sd0, 16'sd0, 2'd0, 2'd0, 4'd3, 1'b0);
        epoch(16'sd63, 16'sd0, 16'sd0, 16'sd0, 2'd0, 2'd0, 4'd3, 1'b1);

        // Scenario 5: backpressure with in_valid pulses
        accept(16'sd0, 16'sd0, 16'sd0, 16'sd512, 2'd3);
        wait_out();
        check_out(2'd0, 4'd3, 1'b0);
        o0 = 16'sd0; o1 = 16'sd512; o2 = 16'sd0; o3 = 16'sd0; predicted_stage = 2'd1;
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            @(negedge clk);
            chk("bp_out_valid", {15'd0, out_valid}, 16'd1);
            chk("bp_in_ready", {15'd0, in_ready}, 16'd0);
            check_out(2'd0, 4'd3, 1'b0);
        end
        in_valid = 1'b0;
        handshake();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_no_accept", {15'd0, out_valid}, 16'd0);
            chk("bp_epoch_hold", epoch_cnt, 16'(exp_ep));
        end

        // Scenario 6: reset during UPDATE, then a clean repeat of scenario 1
        accept(16'sd0, 16'sd512, 16'sd0, 16'sd0, 2'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_ep = 0;
        @(negedge clk);
        check_reset_outputs();
        epoch(16'sd512, 16'sd100, 16'sd50, 16'sd0, 2'd0, 2'd0, 4'd1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
